// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide HI/LO unit: op codes, default
// latencies, FSM state encoding and op-decode helpers.
package md_pkg;

    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {StIdle, StRun} md_state_e;

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || md_is_div(op);
    endfunction

endpackage

// File: rtl/md_signed_div.sv
// Combinational sign-magnitude divider. Quotient truncates toward zero and
// the remainder takes the dividend's sign. A zero divisor yields zeros; the
// caller never commits that case.
module md_signed_div (
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Divide magnitudes, then restore signs.
    always_comb begin
        neg_a = is_signed & dividend[31];
        neg_b = is_signed & divisor[31];
        mag_a = neg_a ? (~dividend + 32'd1) : dividend;
        mag_b = neg_b ? (~divisor + 32'd1) : divisor;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (mag_b != 32'd0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        quotient  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
        remainder = neg_a ? (~r_mag + 32'd1) : r_mag;
    end

endmodule

// File: rtl/md_hilo_unit.sv
// Multiply/divide responder owning HI/LO. The result is computed at issue and
// held in pending registers; a down-counter models the fixed latency before
// it is committed. Optional feature macro: MD_FLUSH_EN (abort in-flight op).
module md_hilo_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic        hi_lo_sel,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        div0
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic               div0_q, div0_d;

    logic               flush_act;
    logic               is_div;
    logic               issue_ok;
    logic               accept;
    logic [63:0]        a_ext, b_ext, prod;
    logic [31:0]        quo, rem;

`ifdef MD_FLUSH_EN
    assign flush_act = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_act    = 1'b0;
`endif

    md_signed_div u_div (
        .dividend  (a),
        .divisor   (b),
        .is_signed (op == MD_DIV),
        .quotient  (quo),
        .remainder (rem)
    );

    // Issue decode and the 64-bit product (low 64 bits of extended operands).
    always_comb begin
        is_div   = md_is_div(op);
        issue_ok = start && (state_q == StIdle) && !flush_act;
        accept   = issue_ok && md_is_op(op) && !(is_div && (b == 32'd0));
        div0_d   = issue_ok && is_div && (b == 32'd0);
        a_ext    = (op == MD_MULT) ? {{32{a[31]}}, a} : {32'd0, a};
        b_ext    = (op == MD_MULT) ? {{32{b[31]}}, b} : {32'd0, b};
        prod     = a_ext * b_ext;
    end

    // FSM next state, latency counter, pending capture and HI/LO writes.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StRun;
                    cnt_d     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    pend_hi_d = is_div ? rem : prod[63:32];
                    pend_lo_d = is_div ? quo : prod[31:0];
                end else if (!start) begin
                    // Any start this cycle drops a coincident mthi/mtlo.
                    if (hi_we) hi_d = a;
                    if (lo_we) lo_d = a;
                end
            end
            StRun: begin
                if (flush_act) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        hi_d    = pend_hi_q;
                        lo_d    = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            div0_q    <= div0_d;
        end
    end

    // Outputs come straight from committed registers.
    always_comb begin
        rdata = hi_lo_sel ? hi_q : lo_q;
        busy  = (state_q == StRun);
        div0  = div0_q;
    end

endmodule

// File: tb/tb_md_hilo_unit.sv
// Self-checking bench for md_hilo_unit: a table of back-to-back ops with
// hand-computed HI/LO results, then directed multi-cycle corner sequences.
module tb_md_hilo_unit;
    import md_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, hi_we, lo_we, hi_lo_sel, flush;
    logic [3:0]  op;
    logic [31:0] a, b, rdata;
    logic        busy, div0;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
        int          cycles;
    } vec_t;

    vec_t vecs[10];

    md_hilo_unit #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .hi_lo_sel (hi_lo_sel),
        .flush     (flush),
        .rdata     (rdata),
        .busy      (busy),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        hi_lo_sel = 1'b1;
        #1 h = rdata;
        hi_lo_sel = 1'b0;
        #1 l = rdata;
    endtask

    task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        logic [31:0] h, l;
        read_hilo(h, l);
        check({name, "_hi"}, h, eh);
        check({name, "_lo"}, l, el);
    endtask

    // Called at a negedge; returns at the negedge where busy is first 0.
    task automatic wait_idle(input int seen, output int n);
        n = seen;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        op    = v.op;
        a     = v.a;
        b     = v.b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("v%0d_div0", idx), {31'd0, div0}, {31'd0, v.div0});
        wait_idle(0, n);
        check($sformatf("v%0d_busy_cycles", idx), n, v.cycles);
        check_hilo($sformatf("v%0d", idx), v.hi, v.lo);
    endtask

    initial begin
        int n;
        vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, MC};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1'b0, MC};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DC};
        vecs[3] = '{MD_DIVU,  32'd7,        32'd2,        32'd1,        32'd3,        1'b0, DC};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, DC};
        vecs[5] = '{MD_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0, DC};
        vecs[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, DC};
        vecs[7] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0, MC};
        vecs[8] = '{MD_DIV,   32'd5,        32'd0,        32'h40000000, 32'd0,        1'b1, 0};
        vecs[9] = '{4'd0,     32'd9,        32'd9,        32'h40000000, 32'd0,        1'b0, 0};

        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        hi_lo_sel = 1'b0; flush = 1'b0; op = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_div0", {31'd0, div0}, 32'd0);
        check_hilo("rst", 32'd0, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back table: each issue lands in the first cycle busy is 0.
        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // mtlo / mthi while idle.
        a = 32'h12345678; lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0; hi_lo_sel = 1'b0;
        #1 check("mtlo_rdata", rdata, 32'h12345678);
        a = 32'hCAFEF00D; hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        check_hilo("mthi", 32'hCAFEF00D, 32'h12345678);

        // start with coincident mtlo: write dropped; then writes/start while busy ignored.
        op = MD_MULTU; a = 32'd3; b = 32'd5; start = 1'b1; lo_we = 1'b1;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        check("coinc_busy", {31'd0, busy}, 32'd1);
        check_hilo("coinc_nowrite", 32'hCAFEF00D, 32'h12345678);
        op = MD_MULT; a = 32'hDEADBEEF; b = 32'd2; start = 1'b1; lo_we = 1'b1; hi_we = 1'b1;
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
        check_hilo("busy_nowrite", 32'hCAFEF00D, 32'h12345678);
        wait_idle(1, n);
        check("busy_start_cycles", n, MC);
        check_hilo("multu_3x5", 32'd0, 32'd15);

        // Reset in the 3rd busy cycle of a divide discards the result.
        op = MD_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check_hilo("midrst", 32'd0, 32'd0);
        repeat (12) @(negedge clk);
        check("midrst_busy_later", {31'd0, busy}, 32'd0);
        check_hilo("midrst_later", 32'd0, 32'd0);

        // flush in the 3rd busy cycle of a divide.
        op = MD_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
`ifdef MD_FLUSH_EN
        check("flush_busy", {31'd0, busy}, 32'd0);
        check_hilo("flush", 32'd0, 32'd0);
        repeat (12) @(negedge clk);
        check_hilo("flush_later", 32'd0, 32'd0);
`else
        check("noflush_busy", {31'd0, busy}, 32'd1);
        wait_idle(3, n);
        check("noflush_cycles", n, DC);
        check_hilo("noflush_div", 32'd2, 32'd14);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
